// File: rtl/qvalue_scanner.sv
// qvalue_scanner: sweeps a table of big-endian 16-bit words and reports the max.
// Define SCAN_WRITEBACK_EN to add a WRITE state that stores best_index at wb_addr.
module qvalue_scanner #(
  parameter int MAX_COUNT = 64,
  parameter int IDX_W     = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      base_addr,
  input  logic [6:0]       count,
  input  logic [15:0]      wb_addr,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] best_index,
  output logic [15:0]      best_value,
  output logic [15:0]      mem_address,
  output logic             mem_wr_en,
  output logic [15:0]      mem_data_in,
  input  logic [15:0]      mem_data_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DONE  = 2'd2
`ifdef SCAN_WRITEBACK_EN
    , ST_WRITE = 2'd3
`endif
  } state_e;

  localparam logic [6:0] MAX_N = 7'(MAX_COUNT);

  state_e state_q, state_d;

  logic [6:0]       n_q, n_d;
  logic [6:0]       idx_q, idx_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      best_value_q, best_value_d;
  logic [IDX_W-1:0] best_index_q, best_index_d;
  logic             found_q, found_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifdef SCAN_WRITEBACK_EN
  logic             wr_en_q, wr_en_d;
  logic [15:0]      wdata_q, wdata_d;
`endif

  logic [6:0] n_clamp;
  logic       take;
  logic       last;

  // Clamp the requested length to the table capacity.
  always_comb begin
    n_clamp = count;
    if (count > MAX_N) begin
      n_clamp = MAX_N;
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    take = !found_q || (mem_data_out > best_value_q);
    last = (idx_q == (n_q - 7'd1));
  end

  // Next-state and datapath updates for the scan sequencer.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    best_value_d = best_value_q;
    best_index_d = best_index_q;
    found_d      = found_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
`ifdef SCAN_WRITEBACK_EN
    wr_en_d      = 1'b0;
    wdata_d      = wdata_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          n_d          = n_clamp;
          addr_d       = base_addr;
          idx_d        = 7'd0;
          best_value_d = 16'd0;
          best_index_d = '0;
          found_d      = 1'b0;
          if (n_clamp == 7'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_SCAN;
            busy_d  = 1'b1;
          end
        end
      end

      ST_SCAN: begin
        if (take) begin
          best_value_d = mem_data_out;
          best_index_d = IDX_W'(idx_q);
          found_d      = 1'b1;
        end
        if (last) begin
`ifdef SCAN_WRITEBACK_EN
          state_d = ST_WRITE;
          addr_d  = wb_addr;
          wr_en_d = 1'b1;
          wdata_d = 16'(best_index_d);
`else
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
`endif
        end else begin
          addr_d = addr_q + 16'd2;
          idx_d  = idx_q + 7'd1;
        end
      end

`ifdef SCAN_WRITEBACK_EN
      ST_WRITE: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      n_q          <= 7'd0;
      idx_q        <= 7'd0;
      addr_q       <= 16'd0;
      best_value_q <= 16'd0;
      best_index_q <= '0;
      found_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      best_value_q <= best_value_d;
      best_index_q <= best_index_d;
      found_q      <= found_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef SCAN_WRITEBACK_EN
  // Write-back strobe and data, live only in WRITE.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en_q <= 1'b0;
      wdata_q <= 16'd0;
    end else begin
      wr_en_q <= wr_en_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_wr_en   = wr_en_q;
  assign mem_data_in = wdata_q;
`else
  logic unused_wb_addr;

  assign unused_wb_addr = ^wb_addr;
  assign mem_wr_en      = 1'b0;
  assign mem_data_in    = 16'd0;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign best_index  = best_index_q;
  assign best_value  = best_value_q;
  assign mem_address = addr_q;

endmodule
